// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the L1/L2 memory-port arbiter
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_I,
        ARB_D
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } arb_owner_t;

    // The port owner follows directly from the arbiter state.
    function automatic arb_owner_t owner_of(input arb_state_t s);
        case (s)
            ARB_I:   return OWN_I;
            ARB_D:   return OWN_D;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one lower-memory port between I-cache and D-cache
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_WIDTH   = 256,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  arb_busy
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
    logic                   pmem_read_q, pmem_read_d;
    logic                   pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0]  pmem_address_q, pmem_address_d;
    logic [LINE_WIDTH-1:0]  pmem_wdata_q, pmem_wdata_d;

    arb_owner_t owner;
    logic       d_req;
    logic       i_req;

    assign d_req = d_pmem_read | d_pmem_write;
    assign i_req = i_pmem_read;
    assign owner = owner_of(state_q);

    // Arbitrate in idle, latch the winner's command, release the port on resp.
    always_comb begin
        state_d        = state_q;
        starve_cnt_d   = starve_cnt_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (d_req && (!i_req || starve_cnt_q < LIMIT)) begin
                    state_d        = ARB_D;
                    pmem_address_d = d_pmem_address;
                    pmem_wdata_d   = d_pmem_wdata;
                    // A simultaneous read+write is illegal; the write-back wins.
                    pmem_write_d   = d_pmem_write;
                    pmem_read_d    = d_pmem_read & ~d_pmem_write;
                    if (i_req) begin
                        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT
                                                               : starve_cnt_q + CNT_W'(1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                end else if (i_req) begin
                    state_d        = ARB_I;
                    pmem_address_d = i_pmem_address;
                    pmem_read_d    = 1'b1;
                    pmem_write_d   = 1'b0;
                    starve_cnt_d   = '0;
                end else begin
                    starve_cnt_d = '0;
                end
            end
            ARB_I, ARB_D: begin
                if (pmem_resp) begin
                    state_d      = ARB_IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, starvation counter and registered lower-port command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ARB_IDLE;
            starve_cnt_q   <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            starve_cnt_q   <= starve_cnt_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
        end
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign arb_busy     = (state_q != ARB_IDLE);

    // Responses pass straight through to the owner only; the other side sees zeros.
    assign i_pmem_resp  = (owner == OWN_I) & pmem_resp;
    assign d_pmem_resp  = (owner == OWN_D) & pmem_resp;
    assign i_pmem_rdata = (owner == OWN_I) ? pmem_rdata : '0;
    assign d_pmem_rdata = (owner == OWN_D) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    localparam int LW  = 256;
    localparam int AW  = 32;
    localparam int LIM = 4;
    localparam int WHO_NONE = 0;
    localparam int WHO_I    = 1;
    localparam int WHO_D    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
    logic          arb_busy;

    cache_mem_arbiter #(
        .LINE_WIDTH(LW),
        .ADDR_WIDTH(AW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_pmem_read(i_pmem_read),
        .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata),
        .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address),
        .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata),
        .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: D grants in a row while I waits, and the last written line.
    int            streak    = 0;
    logic [LW-1:0] last_wdata = '0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return {$urandom} & 32'hFFFF_FFE0;
    endfunction

    task automatic model_reset();
        streak     = 0;
        last_wdata = '0;
    endtask

    // Predict the winner from the requests being driven, step one clock, check the port.
    task automatic grant(output int who, output logic [AW-1:0] exp_addr);
        bit ir, dr;
        logic exp_rd, exp_wr;
        logic [LW-1:0] exp_wd;
        n_assert++;
        assert (!(d_pmem_read && d_pmem_write)) else begin
            n_fail++;
            $error("FAIL illegal_d_rw: observed 1 expected 0");
        end
        ir = i_pmem_read;
        dr = d_pmem_read | d_pmem_write;
        exp_addr = '0;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (dr && (!ir || streak < LIM)) begin
            who = WHO_D;
            streak = ir ? ((streak + 1 > LIM) ? LIM : streak + 1) : 0;
            exp_addr = d_pmem_address;
            exp_wr = d_pmem_write;
            exp_rd = d_pmem_read;
            last_wdata = d_pmem_wdata;
        end else if (ir) begin
            who = WHO_I;
            streak = 0;
            exp_addr = i_pmem_address;
            exp_rd = 1'b1;
        end else begin
            who = WHO_NONE;
            streak = 0;
        end
        exp_wd = last_wdata;
        @(negedge clk);
        if (who == WHO_NONE) begin
            chk("idle_busy", LW'(arb_busy), LW'(0));
            chk("idle_read", LW'(pmem_read), LW'(0));
            chk("idle_write", LW'(pmem_write), LW'(0));
        end else begin
            chk("grant_busy", LW'(arb_busy), LW'(1));
            chk("grant_read", LW'(pmem_read), LW'(exp_rd));
            chk("grant_write", LW'(pmem_write), LW'(exp_wr));
            chk("grant_addr", LW'(pmem_address), LW'(exp_addr));
            chk("grant_wdata", pmem_wdata, exp_wd);
        end
    endtask

    // Lower memory answers after lat cycles; the owner disturbs its address meanwhile.
    task automatic serve(input int who, input int lat, input logic [LW-1:0] rd,
                         input logic [AW-1:0] exp_addr);
        for (int k = 0; k < lat - 1; k++) begin
            if (who == WHO_I) i_pmem_address = i_pmem_address ^ 32'h40;
            else d_pmem_address = d_pmem_address ^ 32'h40;
            pmem_resp = 1'b1 & 1'b0;
            #1;
            chk("wait_i_resp", LW'(i_pmem_resp), LW'(0));
            chk("wait_d_resp", LW'(d_pmem_resp), LW'(0));
            @(negedge clk);
            chk("hold_addr", LW'(pmem_address), LW'(exp_addr));
            chk("hold_busy", LW'(arb_busy), LW'(1));
        end
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        chk("resp_i", LW'(i_pmem_resp), LW'(who == WHO_I));
        chk("resp_d", LW'(d_pmem_resp), LW'(who == WHO_D));
        chk("rdata_i", i_pmem_rdata, (who == WHO_I) ? rd : '0);
        chk("rdata_d", d_pmem_rdata, (who == WHO_D) ? rd : '0);
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        if (who == WHO_I) begin
            i_pmem_read = 1'b0;
        end else begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end
        #1;
        chk("after_busy", LW'(arb_busy), LW'(0));
        chk("after_read", LW'(pmem_read), LW'(0));
        chk("after_write", LW'(pmem_write), LW'(0));
        chk("after_i_resp", LW'(i_pmem_resp), LW'(0));
        chk("after_d_resp", LW'(d_pmem_resp), LW'(0));
    endtask

    initial begin
        int who;
        logic [AW-1:0] ea;
        logic [LW-1:0] dead;
        rst = 1'b1;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        dead = {16{16'hDEAD}};
        model_reset();

        // Reset values.
        #1;
        chk("rst_busy", LW'(arb_busy), LW'(0));
        chk("rst_read", LW'(pmem_read), LW'(0));
        chk("rst_write", LW'(pmem_write), LW'(0));
        chk("rst_addr", LW'(pmem_address), LW'(0));
        chk("rst_wdata", pmem_wdata, '0);
        chk("rst_i_resp", LW'(i_pmem_resp), LW'(0));
        chk("rst_d_resp", LW'(d_pmem_resp), LW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // I-only read at 0x60, five-cycle memory.
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h60;
        grant(who, ea);
        chk("t1_addr", LW'(pmem_address), LW'(32'h60));
        serve(who, 5, {32{8'hA5}}, ea);

        // Simultaneous I and D: D first, I after the turnaround.
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h100;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h200;
        d_pmem_wdata = dead;
        grant(who, ea);
        chk("t2_d_write", LW'(pmem_write), LW'(1));
        chk("t2_d_wdata", pmem_wdata, dead);
        serve(who, 2, rand_line(), ea);
        grant(who, ea);
        chk("t2_i_addr", LW'(pmem_address), LW'(32'h100));
        serve(who, 3, rand_line(), ea);

        // Starvation: D back-to-back with I held, twice over.
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h400;
        for (int r = 0; r < 2 * (LIM + 1); r++) begin
            d_pmem_read = 1'b1;
            d_pmem_address = rand_addr();
            if (!i_pmem_read) begin
                i_pmem_read = 1'b1;
                i_pmem_address = 32'h400;
            end
            grant(who, ea);
            chk("starve_is_i", LW'(pmem_address == 32'h400), LW'((r % (LIM + 1)) == LIM));
            serve(who, $urandom_range(1, 3), rand_line(), ea);
        end
        d_pmem_read = 1'b0;
        grant(who, ea);
        serve(who, 1, rand_line(), ea);

        // Address change mid-transaction.
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h300;
        grant(who, ea);
        d_pmem_address = 32'h340;
        @(negedge clk);
        chk("midchg_addr", LW'(pmem_address), LW'(32'h300));
        serve(who, 3, rand_line(), ea);

        // Spurious pmem_resp while idle.
        pmem_resp = 1'b1;
        #1;
        chk("spur_i_resp", LW'(i_pmem_resp), LW'(0));
        chk("spur_d_resp", LW'(d_pmem_resp), LW'(0));
        @(negedge clk);
        chk("spur_busy", LW'(arb_busy), LW'(0));
        chk("spur_read", LW'(pmem_read), LW'(0));
        pmem_resp = 1'b0;
        streak = 0;

        // Asynchronous reset during a D write-back.
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h500;
        d_pmem_wdata = rand_line();
        grant(who, ea);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", LW'(arb_busy), LW'(0));
        chk("arst_write", LW'(pmem_write), LW'(0));
        chk("arst_addr", LW'(pmem_address), LW'(0));
        chk("arst_wdata", pmem_wdata, '0);
        d_pmem_write = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h700;
        grant(who, ea);
        serve(who, 2, rand_line(), ea);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            if (!i_pmem_read && $urandom_range(0, 1) == 1) begin
                i_pmem_read = 1'b1;
                i_pmem_address = rand_addr();
            end
            if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) d_pmem_write = 1'b1;
                else d_pmem_read = 1'b1;
                d_pmem_address = rand_addr();
                d_pmem_wdata = rand_line();
            end
            grant(who, ea);
            if (who != WHO_NONE) serve(who, $urandom_range(1, 6), rand_line(), ea);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
